// File: rtl/b_perceptron_trainer.sv
// rtl/b_perceptron_trainer.sv - speculative GHR, pending-B FIFO and perceptron retrainer for the B predictor.
// Optional macro B_WEIGHT_SATURATE_EN: clamp weight updates to -128..+127 instead of wrapping.
module b_perceptron_trainer #(
    parameter int DEPTH = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_fetchValid,
    input  logic [2:0]   i_passBNum_3,
    input  logic         i_predictGotJ,
    output logic         o_fetchReady,
    input  logic         i_resolveValid,
    input  logic         i_resolveTaken,
    input  logic [31:0]  i_resolveNextPc_32,
    output logic         o_resolveReady,
    output logic [19:0]  o_globalHistoryRegister_20,
    output logic [287:0] o_weights_288,
    output logic [7:0]   o_pendingB_8,
    output logic [2:0]   o_counter_3,
    output logic [31:0]  o_correctPC_32
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, TRAIN} state_t;
    state_t state;

    // Only bits 18:0 of a snapshot are ever consumed (the recovery shift drops bit 19).
    logic [1:0]    fifo_slot [DEPTH];
    logic          fifo_pred [DEPTH];
    logic [18:0]   fifo_ghr  [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   occ, occ_next;

    logic [1:0] tr_slot;
    logic [7:0] tr_ghr;
    logic       tr_taken;
    logic [3:0] tr_k;

    logic        do_push, do_pop, mispredict, idle_next, inc;
    logic [2:0]  n_eff, cnt_sat;
    logic [19:0] push_ghr;
    logic [18:0] snap [4];
    logic        pbit [4];
    logic [8:0]  widx;
    logic [7:0]  cur_w;

    function automatic logic [7:0] upd(input logic [7:0] w, input logic up);
`ifdef B_WEIGHT_SATURATE_EN
        if (up) return (w == 8'h7f) ? w : w + 8'd1;
        else    return (w == 8'h80) ? w : w - 8'd1;
`else
        return up ? w + 8'd1 : w - 8'd1;
`endif
    endfunction

    always_comb begin
        n_eff      = (i_passBNum_3 > 3'd4) ? 3'd4 : i_passBNum_3;
        do_push    = i_fetchValid && o_fetchReady && (i_passBNum_3 != 3'd7);
        do_pop     = i_resolveValid && o_resolveReady && (occ != '0);
        mispredict = do_pop && (i_resolveTaken != fifo_pred[rd_ptr]);
        cnt_sat    = (o_counter_3 == 3'd7) ? 3'd7 : o_counter_3 + 3'd1;
        push_ghr   = o_globalHistoryRegister_20;
        for (int k = 0; k < 4; k++) begin
            snap[k] = push_ghr[18:0];
            pbit[k] = (3'(k) == n_eff - 3'd1) && i_predictGotJ;
            if (3'(k) < n_eff) push_ghr = {push_ghr[18:0], pbit[k]};
        end
        if (mispredict)
            occ_next = '0;
        else
            occ_next = occ + (do_push ? (AW+1)'(n_eff) : '0) - (do_pop ? (AW+1)'(1) : '0);
        idle_next = (state == TRAIN) ? (tr_k == 4'd8) : !mispredict;
        widx  = 9'(tr_slot) * 9'd72 + {2'b00, tr_k, 3'b000};
        cur_w = o_weights_288[widx +: 8];
        inc   = (tr_k == 4'd8) ? tr_taken : (tr_ghr[tr_k[2:0]] == tr_taken);
    end

    always_ff @(posedge i_clk) begin
        if (do_push && !mispredict) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < n_eff) begin
                    fifo_slot[wr_ptr + AW'(k)] <= 2'(k);
                    fifo_pred[wr_ptr + AW'(k)] <= pbit[k];
                    fifo_ghr[wr_ptr + AW'(k)]  <= snap[k];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state                      <= IDLE;
            rd_ptr                     <= '0;
            wr_ptr                     <= '0;
            occ                        <= '0;
            o_globalHistoryRegister_20 <= '0;
            o_weights_288              <= '0;
            o_counter_3                <= '0;
            o_correctPC_32             <= '0;
            o_fetchReady               <= 1'b1;
            o_resolveReady             <= 1'b1;
            tr_slot                    <= '0;
            tr_ghr                     <= '0;
            tr_taken                   <= 1'b0;
            tr_k                       <= '0;
        end else begin
            o_correctPC_32 <= mispredict ? i_resolveNextPc_32 : 32'd0;
            o_fetchReady   <= idle_next && (occ_next <= (AW+1)'(DEPTH - 4));
            o_resolveReady <= idle_next;
            occ            <= occ_next;
            case (state)
                IDLE: begin
                    if (mispredict) begin
                        // Mispredict wins over a same-cycle push: flush and rebuild history.
                        state                      <= TRAIN;
                        rd_ptr                     <= wr_ptr;
                        o_globalHistoryRegister_20 <= {fifo_ghr[rd_ptr], i_resolveTaken};
                        tr_slot                    <= fifo_slot[rd_ptr];
                        tr_ghr                     <= fifo_ghr[rd_ptr][7:0];
                        tr_taken                   <= i_resolveTaken;
                        tr_k                       <= {2'b00, fifo_slot[rd_ptr]};
                        o_counter_3                <= cnt_sat;
                    end else begin
                        if (do_pop) rd_ptr <= rd_ptr + AW'(1);
                        if (do_push) begin
                            wr_ptr                     <= wr_ptr + AW'(n_eff);
                            o_globalHistoryRegister_20 <= push_ghr;
                            o_counter_3                <= do_pop ? 3'd1 : 3'd0;
                        end else if (do_pop) begin
                            o_counter_3 <= cnt_sat;
                        end
                    end
                end
                TRAIN: begin
                    o_weights_288[widx +: 8] <= upd(cur_w, inc);
                    tr_k                     <= tr_k + 4'd1;
                    if (tr_k == 4'd8) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_pendingB_8 = 8'(occ);
endmodule

// File: tb/tb_b_perceptron_trainer.sv
// tb/tb_b_perceptron_trainer.sv - table-driven and randomized check of b_perceptron_trainer against a queue model.
module tb_b_perceptron_trainer;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         fv, gotj, rv, rt;
    logic [2:0]   num;
    logic [31:0]  rpc;
    logic         fr, rr;
    logic [19:0]  ghr;
    logic [287:0] wts;
    logic [7:0]   pend;
    logic [2:0]   cnt;
    logic [31:0]  cpc;

    b_perceptron_trainer #(.DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_fetchValid(fv), .i_passBNum_3(num), .i_predictGotJ(gotj), .o_fetchReady(fr),
        .i_resolveValid(rv), .i_resolveTaken(rt), .i_resolveNextPc_32(rpc), .o_resolveReady(rr),
        .o_globalHistoryRegister_20(ghr), .o_weights_288(wts), .o_pendingB_8(pend),
        .o_counter_3(cnt), .o_correctPC_32(cpc)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: queue of pending Bs, list of scheduled weight updates.
    typedef struct { logic [1:0] slot; logic pred; logic [19:0] g; } ent_t;
    typedef struct { int p; int j; logic up; } upd_t;
    ent_t        mq[$];
    upd_t        tq[$];
    logic [19:0] m_ghr;
    int          m_w[4][9];
    int          m_cnt;
    logic [31:0] m_cpc;

    function automatic int wadd(input int w, input logic up);
        int r = w + (up ? 1 : -1);
`ifdef B_WEIGHT_SATURATE_EN
        if (r > 127) r = 127;
        if (r < -128) r = -128;
`else
        if (r > 127) r -= 256;
        if (r < -128) r += 256;
`endif
        return r;
    endfunction

    function automatic logic m_rr();
        return tq.size() == 0;
    endfunction

    function automatic logic m_fr();
        return (tq.size() == 0) && (mq.size() <= DEPTH - 4);
    endfunction

    function automatic logic [287:0] m_wflat();
        logic [287:0] r = '0;
        for (int p = 0; p < 4; p++)
            for (int j = 0; j < 9; j++)
                r[p*72 + j*8 +: 8] = 8'(m_w[p][j]);
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        tq.delete();
        m_ghr = '0;
        m_cnt = 0;
        m_cpc = '0;
        for (int p = 0; p < 4; p++)
            for (int j = 0; j < 9; j++) m_w[p][j] = 0;
    endtask

    task automatic model_edge();
        upd_t u;
        ent_t e;
        logic push, pop, pr;
        m_cpc = '0;
        if (tq.size() != 0) begin
            u = tq.pop_front();
            m_w[u.p][u.j] = wadd(m_w[u.p][u.j], u.up);
        end else begin
            push = fv && m_fr() && (num != 3'd7);
            pop  = rv && (mq.size() > 0);
            if (pop && (rt != mq[0].pred)) begin
                e = mq[0];
                m_cpc = rpc;
                m_ghr = {e.g[18:0], rt};
                mq.delete();
                for (int j = e.slot; j <= 8; j++) begin
                    u.p = e.slot;
                    u.j = j;
                    u.up = (j == 8) ? rt : (e.g[j] == rt);
                    tq.push_back(u);
                end
                m_cnt = (m_cnt == 7) ? 7 : m_cnt + 1;
            end else begin
                if (pop) begin
                    void'(mq.pop_front());
                    m_cnt = (m_cnt == 7) ? 7 : m_cnt + 1;
                end
                if (push) begin
                    for (int k = 0; k < num; k++) begin
                        pr = (k == num - 1) && gotj;
                        e.slot = 2'(k);
                        e.pred = pr;
                        e.g = m_ghr;
                        mq.push_back(e);
                        m_ghr = {m_ghr[18:0], pr};
                    end
                    m_cnt = pop ? 1 : 0;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [287:0] ew;
        chk("ghr", 32'(ghr), 32'(m_ghr));
        chk("pendingB", 32'(pend), 32'(mq.size()));
        chk("counter", 32'(cnt), 32'(m_cnt));
        chk("correctPC", cpc, m_cpc);
        chk("fetchReady", 32'(fr), 32'(m_fr()));
        chk("resolveReady", 32'(rr), 32'(m_rr()));
        ew = m_wflat();
        checks++;
        if (wts !== ew) begin
            errors++;
            $display("FAIL weights: got %h expected %h at %0t", wts, ew, $time);
        end
    endtask

    task automatic drive(input logic f, input logic [2:0] n, input logic g,
                         input logic r, input logic t, input logic [31:0] pc);
        fv = f; num = n; gotj = g; rv = r; rt = t; rpc = pc;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_model();
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 32'h4);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 32'h4);
        model_reset();
        #2;
        check_model();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic fv; logic [2:0] num; logic gotj; logic rv; logic rt; logic [31:0] rpc;
        logic [19:0] e_ghr; logic [7:0] e_pend; logic [2:0] e_cnt; logic [31:0] e_cpc; logic e_rr;
    } vec_t;
    vec_t tbl[$];

    function automatic void addv(input logic f, input logic [2:0] n, input logic g,
                                 input logic r, input logic t, input logic [31:0] pc,
                                 input logic [19:0] eg, input logic [7:0] ep, input logic [2:0] ec,
                                 input logic [31:0] epc, input logic err);
        vec_t v;
        v.fv = f; v.num = n; v.gotj = g; v.rv = r; v.rt = t; v.rpc = pc;
        v.e_ghr = eg; v.e_pend = ep; v.e_cnt = ec; v.e_cpc = epc; v.e_rr = err;
        tbl.push_back(v);
    endfunction

    initial begin
        vec_t v;
        int guard;
        int pick;
        drive(0, 0, 0, 0, 0, 32'h4);
        model_reset();

        // Push 3 (last taken), resolve all correctly.
        addv(1, 3, 1, 0, 0, 32'h4, 20'h00001, 3, 0, 0, 1);
        addv(0, 0, 0, 1, 0, 32'h4, 20'h00001, 2, 1, 0, 1);
        addv(0, 0, 0, 1, 0, 32'h4, 20'h00001, 1, 2, 0, 1);
        addv(0, 0, 0, 1, 1, 32'h4, 20'h00001, 0, 3, 0, 1);
        // Build GHR 0xFF, then a slot-0 mispredict.
        addv(1, 1, 1, 1, 1, 32'h4, 20'h00003, 1, 0, 0, 1);
        for (int i = 2; i <= 7; i++)
            addv(1, 1, 1, 1, 1, 32'h4, 20'((1 << (i + 1)) - 1), 1, 1, 0, 1);
        addv(0, 0, 0, 1, 1, 32'h4, 20'h000FF, 0, 2, 0, 1);
        addv(1, 1, 0, 0, 0, 32'h4, 20'h001FE, 1, 0, 0, 1);
        addv(0, 0, 0, 1, 1, 32'h1000, 20'h001FF, 0, 1, 32'h1000, 0);
        for (int i = 0; i < 8; i++) addv(0, 0, 0, 0, 0, 32'h4, 20'h001FF, 0, 1, 0, 0);
        addv(0, 0, 0, 0, 0, 32'h4, 20'h001FF, 0, 1, 0, 1);
        // Slot-2 mispredict: 7 training cycles.
        addv(1, 3, 0, 0, 0, 32'h4, 20'h00FF8, 3, 0, 0, 1);
        addv(0, 0, 0, 1, 0, 32'h4, 20'h00FF8, 2, 1, 0, 1);
        addv(0, 0, 0, 1, 0, 32'h4, 20'h00FF8, 1, 2, 0, 1);
        addv(0, 0, 0, 1, 1, 32'h2000, 20'h00FF9, 0, 3, 32'h2000, 0);
        for (int i = 0; i < 6; i++) addv(0, 0, 0, 0, 0, 32'h4, 20'h00FF9, 0, 3, 0, 0);
        addv(0, 0, 0, 0, 0, 32'h4, 20'h00FF9, 0, 3, 0, 1);

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            drive(v.fv, v.num, v.gotj, v.rv, v.rt, v.rpc);
            step();
            chk($sformatf("t%0d_ghr", i), 32'(ghr), 32'(v.e_ghr));
            chk($sformatf("t%0d_pend", i), 32'(pend), 32'(v.e_pend));
            chk($sformatf("t%0d_cnt", i), 32'(cnt), 32'(v.e_cnt));
            chk($sformatf("t%0d_cpc", i), cpc, v.e_cpc);
            chk($sformatf("t%0d_rready", i), 32'(rr), 32'(v.e_rr));
        end
        chk("p0_bias", 32'(wts[0*72 + 8*8 +: 8]), 32'h01);
        chk("p0_w0", 32'(wts[0*72 + 0*8 +: 8]), 32'h01);
        chk("p2_w1_untouched", 32'(wts[2*72 + 1*8 +: 8]), 32'h00);
        chk("p2_w2", 32'(wts[2*72 + 2*8 +: 8]), 32'h01);
        chk("p2_bias", 32'(wts[2*72 + 8*8 +: 8]), 32'h01);

        // Capacity edge, then push together with a mispredict.
        drive(1, 4, 0, 0, 0, 32'h4); step();
        chk("fr_at_depth_m4", 32'(fr), 32'h1);
        drive(1, 1, 0, 0, 0, 32'h4); step();
        chk("fr_dropped", 32'(fr), 32'h0);
        chk("pend_5", 32'(pend), 32'h5);
        drive(0, 0, 0, 1, 0, 32'h4); step();
        drive(1, 2, 1, 1, 1, 32'h3000); step();
        chk("push_mis_pend", 32'(pend), 32'h0);
        chk("push_mis_cpc", cpc, 32'h3000);
        idle(10);

        // Drive bias of perceptron 0 to +127, then one more increment.
        guard = 0;
        while (m_w[0][8] != 127 && guard < 200) begin
            drive(1, 1, 0, 0, 0, 32'h4); step();
            drive(0, 0, 0, 1, 1, 32'h5000); step();
            idle(10);
            guard++;
        end
        chk("bias_reached_127", 32'(wts[0*72 + 8*8 +: 8]), 32'h7f);
        drive(1, 1, 0, 0, 0, 32'h4); step();
        drive(0, 0, 0, 1, 1, 32'h5000); step();
        idle(10);
`ifdef B_WEIGHT_SATURATE_EN
        chk("bias_overflow", 32'(wts[0*72 + 8*8 +: 8]), 32'h7f);
`else
        chk("bias_overflow", 32'(wts[0*72 + 8*8 +: 8]), 32'h80);
`endif

        // Reset in the middle of a retrain.
        drive(1, 1, 0, 0, 0, 32'h4); step();
        drive(0, 0, 0, 1, 1, 32'h6000); step();
        idle(3);
        do_reset();
        chk("rst_weights_zero", 32'(|wts), 32'h0);
        idle(2);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            pick = $urandom_range(0, 5);
            drive(1'($urandom), (pick == 5) ? 3'd7 : 3'(pick), 1'($urandom),
                  1'($urandom), 1'($urandom), $urandom | 32'h1);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
